instr_sequencer: RTL
====================

# instr_sequencer

Instruction issue unit that drives the processor control block from a program held in a synchronous ROM. It fetches each instruction word and presents it on `ir`. For MVI it also fetches the immediate word and presents it on `din`. It raises `run` and holds everything stable until the control block returns `done`, then retires the instruction and fetches the next one. It sits between program ROM and the control/datapath pair and is the initiator side of the `ir`/`run`/`done` handshake.

## Interface
- `ADDR_W`, 5: ROM address width; program space is 2^ADDR_W words.
- `DATA_W`, 10: instruction/data word width. Field layout is [9] reserved 0, [8:6] opcode, [5:3] X, [2:0] Y/D.
- `TIMEOUT_CYC`, 16: maximum cycles `run` may stay high without `done` before the block errors out.
- `clock` in 1: single clock, all state updates on rising edge.
- `resetn` in 1: synchronous, active-high reset (asserted = 1).
- `start` in 1: one-cycle pulse that begins or resumes execution from IDLE or HALT; ignored elsewhere.
- `rom_addr` out ADDR_W: ROM address, equal to `pc` at all times.
- `rom_data` in DATA_W: ROM read data, valid the cycle after `rom_addr` is sampled.
- `ir` out DATA_W: instruction word to the control block.
- `din` out DATA_W: immediate word for MVI.
- `run` out 1: instruction valid/execute request.
- `done` in 1: completion from the control block.
- `busy` out 1: high in any state other than IDLE, HALT and ERROR.
- `halted` out 1: high in HALT.
- `err` out 1: sticky timeout flag.
- `pc` out ADDR_W: next fetch address.
- `instr_count` out 16: retired instructions, wraps at 2^16.

## Operation
- Reset values: `pc`=0, `ir`=0, `din`=0, `run`=0, `busy`=0, `halted`=0, `err`=0, `instr_count`=0, watchdog=0, state=IDLE.
- IDLE: on `start`, go to FETCH.
- FETCH (1 cycle): `rom_addr`=`pc` is sampled by the ROM. Next state is LATCH.
- LATCH: `ir`<=`rom_data`, `pc`<=`pc`+1.
  - Opcode 111 (HALT): go to HALT. `ir` keeps the HALT word and `run` is never raised.
  - Opcode 001 (MVI): go to IMM_FETCH.
  - Any other opcode: go to ISSUE.
- IMM_FETCH: go to IMM_LATCH.
- IMM_LATCH: `din`<=`rom_data`, `pc`<=`pc`+1, go to ISSUE.
- ISSUE:
  - `run`=1; `ir` and `din` are held stable.
  - Watchdog increments each cycle.
  - If `done`=1 is sampled: `run`<=0, `instr_count`<=+1, go to RETIRE.
  - If the watchdog reaches TIMEOUT_CYC first: `run`<=0, `err`<=1, go to ERROR.
- RETIRE (1 cycle): `run`=0 so the control block clears its outputs. Watchdog<=0. Go to FETCH.
- HALT: `halted`=1. On `start`, go to FETCH at the current `pc`, i.e. the word after HALT.
- ERROR: terminal until `resetn`. `start` is ignored.
- `pc` wraps from 2^ADDR_W−1 to 0 silently. An MVI at the last address takes its immediate from address 0.
- `done` sampled high outside ISSUE is ignored.
- `resetn` wins over every other event, including `done` and a watchdog expiry in the same cycle. `run` is low the cycle after reset is sampled.
- `done` and watchdog expiry in the same cycle: `done` wins, and the instruction retires normally.

## Timing
- Non-MVI instruction: FETCH, LATCH, then ISSUE. `run` rises 2 cycles after entering FETCH.
- MVI instruction: `run` rises 4 cycles after entering FETCH.
- `run` falls on the edge where `done`=1 is sampled, followed by 1 cycle of RETIRE.
- Throughput: (2 or 4) + N_exec + 1 cycles per instruction. N_exec is the number of cycles `run` is high, including the `done` cycle.
- `start` to first `rom_addr` sample: `start` is sampled in IDLE, and FETCH is the next cycle.
- Registered outputs are `ir`, `din`, `run`, `pc`, `err` and `instr_count`.
- `busy` and `halted` are decoded from state.

## Structure
- Shared package holds:
  - Opcode constants MV=000, MVI=001, ADD=010, SUB=011, LD=100, ST=101, MVNZ=110, HALT=111. These are shared with the control block.
  - Instruction field slice positions.
  - The state encoding: IDLE, FETCH, LATCH, IMM_FETCH, IMM_LATCH, ISSUE, RETIRE, HALT, ERROR.
- One sub-module, `issue_watchdog`: a clearable up-counter with terminal-count output, parameterised by TIMEOUT_CYC.

## Test plan
- Program [MV R1,R2 (0x00A); HALT (0x1C0)], `done` returned on the 1st `run` cycle:
  - `ir`=0x00A with `run` high for exactly 1 cycle, then `halted`=1.
  - Final state `pc`=2, `instr_count`=1.
- MVI at address 0 (0x048) with immediate 0x155 at address 1:
  - `din`=0x155 is stable before `run` rises.
  - `run` rises 4 cycles after FETCH; `pc`=2 after retire.
- ADD with `done` after 3 `run` cycles:
  - `ir` is unchanged for all 3 cycles and RETIRE shows `run`=0 for 1 cycle.
  - The next fetch uses `rom_addr`=`pc`+1.
- `done` held low:
  - `err`=1 and `run`=0 after TIMEOUT_CYC=16 cycles.
  - `start` is then ignored; `resetn` restores all reset values.
- MVI at address 31 (ADDR_W=5): immediate is read from address 0 and `pc`=1 afterwards.
- `resetn` pulsed while in ISSUE with `done`=1 in the same cycle: `run`=0, `instr_count`=0, `pc`=0, and state is IDLE.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// instr_sequencer_pkg : opcodes, instruction fields, sequencer state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

  // Shared with the control block; values are fixed by the instruction set
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int RSV_BIT = 9;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int X_MSB   = 5;
  localparam int X_LSB   = 3;
  localparam int Y_MSB   = 2;
  localparam int Y_LSB   = 0;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_LATCH     = 4'd2,
    ST_IMM_FETCH = 4'd3,
    ST_IMM_LATCH = 4'd4,
    ST_ISSUE     = 4'd5,
    ST_RETIRE    = 4'd6,
    ST_HALT      = 4'd7,
    ST_ERROR     = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_issue_watchdog.sv
// ============================================================================
// issue_watchdog : clearable up-counter flagging the last allowed ISSUE cycle
// Revision 1.0
// ============================================================================
`default_nettype none

module issue_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (resetn || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Asserted during the cycle whose closing edge makes the count reach TIMEOUT_CYC
  assign expired = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : fetches instructions (and MVI immediates) from ROM and
//                   issues them to the control block via run/done
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  state_t     state;
  state_t     next_state;
  logic [2:0] fetched_op;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  assign fetched_op = rom_data[OPC_MSB:OPC_LSB];
  assign rom_addr   = pc;
  assign wd_clear   = (state == ST_RETIRE);
  assign wd_enable  = (state == ST_ISSUE);

  issue_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clock  (clock),
    .resetn (resetn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clock) begin
    if (resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (start) next_state = ST_FETCH;
      ST_FETCH:     next_state = ST_LATCH;
      ST_LATCH: begin
        if (fetched_op == OP_HALT) begin
          next_state = ST_HALT;
        end else if (fetched_op == OP_MVI) begin
          next_state = ST_IMM_FETCH;
        end else begin
          next_state = ST_ISSUE;
        end
      end
      ST_IMM_FETCH: next_state = ST_IMM_LATCH;
      ST_IMM_LATCH: next_state = ST_ISSUE;
      // done takes priority over a simultaneous watchdog expiry
      ST_ISSUE: begin
        if (done) begin
          next_state = ST_RETIRE;
        end else if (wd_expired) begin
          next_state = ST_ERROR;
        end
      end
      ST_RETIRE:    next_state = ST_FETCH;
      ST_HALT:      if (start) next_state = ST_FETCH;
      ST_ERROR:     next_state = ST_ERROR;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b1;
    halted = 1'b0;
    case (state)
      ST_IDLE, ST_ERROR: busy = 1'b0;
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      ir          <= '0;
      din         <= '0;
      run         <= 1'b0;
      pc          <= '0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      run <= (next_state == ST_ISSUE);
      if (state == ST_LATCH) begin
        ir <= rom_data;
        pc <= pc + ADDR_W'(1);
      end
      if (state == ST_IMM_LATCH) begin
        din <= rom_data;
        pc  <= pc + ADDR_W'(1);
      end
      if (state == ST_ISSUE && done) begin
        instr_count <= instr_count + 16'd1;
      end
      if (state == ST_ISSUE && !done && wd_expired) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
